// File: rtl/maze_memory_responder.sv
// maze_memory_responder
//   Memory-side responder for the maze-solver rat's cell-access port.
//   It holds a 2^N x 2^N single-bit map (1 = wall or visited, 0 = free).
//   The map is loaded row by row through a valid/ready port. After loading,
//   the block serves single-cycle RD/WR strobes. Read data is registered,
//   so D_out is valid the cycle after RD.
//
//   Optional feature macro: MAZE_MEM_WR_PROTECT_EN
//     When defined, a shadow copy of the loaded walls is kept. A WR to a cell
//     that was loaded as 1 is silently dropped, so loaded walls can never be
//     cleared.
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   X, Y        column / row of the accessed cell
//   RD, WR      one-cycle read / write strobes
//   D_in        write data from the rat
//   D_out       registered read data (1 when a read is refused)
//   load_start  pulse that begins (or restarts) a full map load
//   load_valid  load_row is valid this cycle
//   load_row    one map row; bit i is the cell at X=i
//   load_ready  a row is accepted when load_valid && load_ready
//   maze_ready  map is loaded and RD/WR are being served
//   access_err  sticky flag: RD or WR seen while maze_ready=0
module maze_memory_responder #(
   parameter int N    = 4,
   parameter int ROWS = 2**N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    X,
   input  logic [N-1:0]    Y,
   input  logic            RD,
   input  logic            WR,
   input  logic            D_in,
   output logic            D_out,
   input  logic            load_start,
   input  logic            load_valid,
   input  logic [ROWS-1:0] load_row,
   output logic            load_ready,
   output logic            maze_ready,
   output logic            access_err
);

   typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

   state_t          state;
   logic [N-1:0]    row_cnt;
   logic [ROWS-1:0] map [ROWS];
   logic            wr_allowed;

`ifdef MAZE_MEM_WR_PROTECT_EN
   logic [ROWS-1:0] shadow [ROWS];
   assign wr_allowed = ~shadow[Y][X];
`else
   assign wr_allowed = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         row_cnt    <= '0;
         D_out      <= 1'b1;
         load_ready <= 1'b0;
         maze_ready <= 1'b0;
         access_err <= 1'b0;
         for (int unsigned i = 0; i < ROWS; i++) begin
            map[i] <= '1;
`ifdef MAZE_MEM_WR_PROTECT_EN
            shadow[i] <= '1;
`endif
         end
      end else begin
         // Accesses outside SERVE are refused: read as wall, flag the error.
         if (state != SERVE) begin
            if (RD)
               D_out <= 1'b1;
            if (RD || WR)
               access_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (load_start) begin
                  state      <= LOAD;
                  row_cnt    <= '0;
                  load_ready <= 1'b1;
               end
            end

            LOAD: begin
               // A restart wins over a row offered in the same cycle.
               if (load_start) begin
                  row_cnt <= '0;
               end else if (load_valid) begin
                  map[row_cnt] <= load_row;
`ifdef MAZE_MEM_WR_PROTECT_EN
                  shadow[row_cnt] <= load_row;
`endif
                  row_cnt <= row_cnt + 1'b1;  // wraps to 0 after the last row
                  if (row_cnt == N'(ROWS - 1)) begin
                     state      <= SERVE;
                     load_ready <= 1'b0;
                     maze_ready <= 1'b1;
                  end
               end
            end

            SERVE: begin
               // Read-before-write: D_out samples the old cell value.
               if (RD)
                  D_out <= map[Y][X];
               if (WR && wr_allowed)
                  map[Y][X] <= D_in;
               if (load_start) begin
                  state      <= LOAD;
                  row_cnt    <= '0;
                  load_ready <= 1'b1;
                  maze_ready <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_memory_responder.sv
// tb_maze_memory_responder
//   Self-checking bench for maze_memory_responder. Expected read data is
//   queued when a read is issued and compared when D_out becomes valid.
module tb_maze_memory_responder;

   localparam int N    = 4;
   localparam int ROWS = 2**N;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    X, Y;
   logic            RD, WR, D_in;
   logic            D_out;
   logic            load_start, load_valid;
   logic [ROWS-1:0] load_row;
   logic            load_ready, maze_ready, access_err;

   maze_memory_responder #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .X          (X),
      .Y          (Y),
      .RD         (RD),
      .WR         (WR),
      .D_in       (D_in),
      .D_out      (D_out),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_row   (load_row),
      .load_ready (load_ready),
      .maze_ready (maze_ready),
      .access_err (access_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic exp_q [$];
   logic [ROWS-1:0] rows [ROWS];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_rd(input string tag, input int x, input int y, input logic exp);
      X  = N'(x);
      Y  = N'(y);
      RD = 1'b1;
      exp_q.push_back(exp);
      tick();
      RD = 1'b0;
      if (exp_q.size() == 0)
         check_eq({tag, "_q"}, 32'd0, 32'd1);
      else
         check_eq(tag, 32'(D_out), 32'(exp_q.pop_front()));
   endtask

   task automatic do_wr(input int x, input int y, input logic d);
      X    = N'(x);
      Y    = N'(y);
      D_in = d;
      WR   = 1'b1;
      tick();
      WR   = 1'b0;
   endtask

   task automatic do_rdwr(input string tag, input int x, input int y, input logic d, input logic exp);
      X    = N'(x);
      Y    = N'(y);
      D_in = d;
      WR   = 1'b1;
      RD   = 1'b1;
      exp_q.push_back(exp);
      tick();
      WR   = 1'b0;
      RD   = 1'b0;
      check_eq(tag, 32'(D_out), 32'(exp_q.pop_front()));
   endtask

   task automatic load_map(input string tag, input bit gap);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check_eq({tag, "_lr"}, 32'(load_ready), 32'd1);
      for (int i = 0; i < ROWS; i++) begin
         if (gap) begin
            load_valid = 1'b0;
            tick();
         end
         if (i == ROWS - 1)
            check_eq({tag, "_mr_early"}, 32'(maze_ready), 32'd0);
         load_row   = rows[i];
         load_valid = 1'b1;
         tick();
         load_valid = 1'b0;
      end
      check_eq({tag, "_mr"}, 32'(maze_ready), 32'd1);
      check_eq({tag, "_lr_done"}, 32'(load_ready), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; X = '0; Y = '0; RD = 1'b0; WR = 1'b0; D_in = 1'b0;
      load_start = 1'b0; load_valid = 1'b0; load_row = '0;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_dout", 32'(D_out), 32'd1);
      check_eq("rst_lr", 32'(load_ready), 32'd0);
      check_eq("rst_mr", 32'(maze_ready), 32'd0);
      check_eq("rst_err", 32'(access_err), 32'd0);

      // Read before any load is refused
      do_rd("rd_idle", 0, 0, 1'b1);
      check_eq("idle_err", 32'(access_err), 32'd1);
      check_eq("idle_mr", 32'(maze_ready), 32'd0);
      check_eq("idle_lr", 32'(load_ready), 32'd0);

      // Gapped load of 16'hFFFE rows
      for (int i = 0; i < ROWS; i++) rows[i] = 16'hFFFE;
      load_map("load1", 1'b1);
      do_rd("rd_0_5", 0, 5, 1'b0);
      do_rd("rd_3_5", 3, 5, 1'b1);

      do_wr(0, 2, 1'b1);
      do_rd("rd_0_2", 0, 2, 1'b1);
      do_wr(0, 3, 1'b0);
      check_eq("dout_hold", 32'(D_out), 32'd1);
      do_rd("rd_0_3", 0, 3, 1'b0);
      do_rdwr("rdwr_0_7", 0, 7, 1'b1, 1'b0);
      do_rd("rd_0_7", 0, 7, 1'b1);
      do_rd("rd_0_5b", 0, 5, 1'b0);
      check_eq("err_sticky", 32'(access_err), 32'd1);

      // Reload from SERVE, abandoned by reset after 3 rows
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check_eq("reload_mr", 32'(maze_ready), 32'd0);
      check_eq("reload_lr", 32'(load_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         load_row   = 16'h0000;
         load_valid = 1'b1;
         tick();
      end
      load_valid = 1'b0;
      check_eq("partial_mr", 32'(maze_ready), 32'd0);
      do_reset();
      check_eq("rst2_dout", 32'(D_out), 32'd1);
      check_eq("rst2_lr", 32'(load_ready), 32'd0);
      check_eq("rst2_mr", 32'(maze_ready), 32'd0);
      check_eq("rst2_err", 32'(access_err), 32'd0);

      for (int i = 0; i < ROWS; i++) rows[i] = 16'h0000;
      load_map("load2", 1'b0);
      do_rd("rd_15_15", 15, 15, 1'b0);
      check_eq("load2_err", 32'(access_err), 32'd0);

      // Wall write protection, loaded after a restart in mid-LOAD
      do_reset();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_row   = 16'hFFFF;
         load_valid = 1'b1;
         tick();
      end
      load_valid = 1'b0;
      for (int i = 0; i < ROWS; i++) rows[i] = 16'h0000;
      rows[4] = 16'h0010;
      load_map("load3", 1'b0);
      do_rd("rd_0_0", 0, 0, 1'b0);
      do_rd("rd_4_4_init", 4, 4, 1'b1);
      do_wr(4, 4, 1'b0);
`ifdef MAZE_MEM_WR_PROTECT_EN
      do_rd("rd_4_4_prot", 4, 4, 1'b1);
`else
      do_rd("rd_4_4_prot", 4, 4, 1'b0);
`endif
      do_wr(5, 4, 1'b1);
      do_rd("rd_5_4_set", 5, 4, 1'b1);
      do_wr(5, 4, 1'b0);
      do_rd("rd_5_4_clr", 5, 4, 1'b0);
      check_eq("prot_err", 32'(access_err), 32'd0);

      check_eq("q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
